// File: rtl/distribute_chain_injector.sv
// rtl/distribute_chain_injector.sv - head-of-chain FIFO source for the one-hot distribution network
//
// Buffers {cmd, data} words and feeds the first distribute_1x2_one_hot_seq
// stage from a registered output stage that advances only with the chain enable.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_valid / o_ready   upstream handshake (o_ready = !o_full)
//   i_data_bus          upstream payload
//   i_dest_mask         bit k set = deliver to node k (node 0 first on chain)
//   i_en                chain enable, shared with the first chain stage
//   o_valid, o_data_bus, o_cmd   registered outputs to the first stage
//   o_count, o_full, o_empty     registered FIFO status
//   o_drop_cnt          saturating count of accepted zero-mask words
module distribute_chain_injector #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_NODES  = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data_bus,
    input  logic [NUM_NODES-1:0]  i_dest_mask,
    input  logic                  i_en,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data_bus,
    output logic [NUM_NODES-1:0]  o_cmd,
    output logic [CNT_WIDTH-1:0]  o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [7:0]            o_drop_cnt
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = NUM_NODES + DATA_WIDTH;

    logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  valid_q, valid_d;
    logic [NUM_NODES-1:0]  cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [7:0]            drop_q, drop_d;

    logic [NUM_NODES-1:0]  cmd_in;
    logic [ENTRY_W-1:0]    head;
    logic                  accept;
    logic                  push;
    logic                  drop;
    logic                  pop;

    always_comb begin
        // The first node on the chain consumes the command MSB, so node k's
        // mask bit lands at position NUM_NODES-1-k.
        cmd_in = '0;
        for (int k = 0; k < NUM_NODES; k++) begin
            cmd_in[NUM_NODES-1-k] = i_dest_mask[k];
        end

        head   = mem_q[rd_ptr_q];
        accept = i_valid && !full_q;
        push   = accept && (|i_dest_mask);
        drop   = accept && !(|i_dest_mask);
        pop    = i_en && !empty_q;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_WIDTH'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_WIDTH'(1);
        end
        full_d  = (count_d == CNT_WIDTH'(FIFO_DEPTH));
        empty_d = (count_d == '0);

        // Output register only advances with the chain enable; an empty FIFO
        // loads an all-zero bubble so the chain sees clean idle words.
        valid_d = valid_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        if (i_en) begin
            if (!empty_q) begin
                valid_d = 1'b1;
                cmd_d   = head[ENTRY_W-1 -: NUM_NODES];
                data_d  = head[DATA_WIDTH-1:0];
            end else begin
                valid_d = 1'b0;
                cmd_d   = '0;
                data_d  = '0;
            end
        end

        drop_d = drop_q;
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            valid_q  <= 1'b0;
            cmd_q    <= '0;
            data_q   <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            valid_q  <= valid_d;
            cmd_q    <= cmd_d;
            data_q   <= data_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: clearing the pointers and count discards entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_in, i_data_bus};
        end
    end

    assign o_ready    = !full_q;
    assign o_valid    = valid_q;
    assign o_cmd      = cmd_q;
    assign o_data_bus = data_q;
    assign o_count    = count_q;
    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_distribute_chain_injector.sv
// tb/tb_distribute_chain_injector.sv - scoreboard bench for distribute_chain_injector
module tb_distribute_chain_injector;

    localparam int DW    = 32;
    localparam int NN    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [DW-1:0] i_data_bus = '0;
    logic [NN-1:0] i_dest_mask = '0;
    logic          i_en = 1'b0;
    logic          o_valid;
    logic [DW-1:0] o_data_bus;
    logic [NN-1:0] o_cmd;
    logic [CW-1:0] o_count;
    logic          o_full;
    logic          o_empty;
    logic [7:0]    o_drop_cnt;

    distribute_chain_injector #(.DATA_WIDTH(DW), .NUM_NODES(NN), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_data_bus(i_data_bus), .i_dest_mask(i_dest_mask), .i_en(i_en),
        .o_valid(o_valid), .o_data_bus(o_data_bus), .o_cmd(o_cmd),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [NN-1:0] cmd;
        logic [DW-1:0] data;
    } out_t;

    int tests = 0;
    int fails = 0;

    // Reference model state: buffered words, issued-word scoreboard, drops.
    out_t mfifo[$];
    out_t sb_q[$];
    int   mdrops  = 0;
    bit   started = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NN-1:0] mask_to_cmd(input logic [NN-1:0] m);
        logic [NN-1:0] c;
        c = '0;
        for (int k = 0; k < NN; k++) c[NN-1-k] = m[k];
        return c;
    endfunction

    // Model: one update per clock edge, from the inputs present at that edge.
    always @(posedge clk) begin
        out_t w;
        int   pre;
        if (rst) begin
            mfifo.delete();
            mdrops  = 0;
            started = 1;
            sb_q.push_back('0);
        end else if (started) begin
            pre = mfifo.size();
            if (i_en) begin
                if (pre > 0) begin
                    w = mfifo.pop_front();
                    sb_q.push_back(w);
                end else begin
                    sb_q.push_back('0);
                end
            end
            if (i_valid && pre < DEPTH) begin
                if (i_dest_mask == '0) begin
                    if (mdrops < 255) mdrops++;
                end else begin
                    w.v    = 1'b1;
                    w.cmd  = mask_to_cmd(i_dest_mask);
                    w.data = i_data_bus;
                    mfifo.push_back(w);
                end
            end
        end
    end

    // Monitor: any scoreboard entry produced by the last edge is what the
    // output register must now show; otherwise the previous word must hold.
    out_t cur = '0;
    always @(negedge clk) begin
        if (started) begin
            if (sb_q.size() > 0) cur = sb_q.pop_front();
            chk("o_valid", 64'(o_valid), 64'(cur.v));
            chk("o_cmd", 64'(o_cmd), 64'(cur.cmd));
            chk("o_data_bus", 64'(o_data_bus), 64'(cur.data));
            chk("o_count", 64'(o_count), 64'(mfifo.size()));
            chk("o_full", 64'(o_full), 64'(mfifo.size() == DEPTH));
            chk("o_empty", 64'(o_empty), 64'(mfifo.size() == 0));
            chk("o_ready", 64'(o_ready), 64'(mfifo.size() != DEPTH));
            chk("o_drop_cnt", 64'(o_drop_cnt), 64'(mdrops));
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic [NN-1:0] m,
                        input logic en, input logic r);
        i_valid     = v;
        i_data_bus  = d;
        i_dest_mask = m;
        i_en        = en;
        rst         = r;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_empty", 64'(o_empty), 64'd1);

        // Single word
        step(1, 32'hAAAAAAAA, 4'b0001, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("single_valid", 64'(o_valid), 64'd1);
        chk("single_cmd", 64'(o_cmd), 64'h8);
        chk("single_data", 64'(o_data_bus), 64'hAAAAAAAA);
        step(0, 0, 0, 1, 0);
        chk("single_after_valid", 64'(o_valid), 64'd0);
        chk("single_after_data", 64'(o_data_bus), 64'd0);

        // Multicast
        step(1, 32'h11, 4'b0101, 1, 0);
        step(1, 32'h22, 4'b1111, 1, 0);
        chk("mcast_cmd_0101", 64'(o_cmd), 64'hA);
        step(0, 0, 0, 1, 0);
        chk("mcast_cmd_1111", 64'(o_cmd), 64'hF);
        step(0, 0, 0, 1, 0);

        // Fill and stall
        for (int i = 0; i < 5; i++) step(1, 32'hB0 + i, 4'b0010, 0, 0);
        chk("fill_full", 64'(o_full), 64'd1);
        chk("fill_ready", 64'(o_ready), 64'd0);
        chk("fill_count", 64'(o_count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            step(1, 32'hB4, 4'b0010, 1, 0);
            chk("fill_order", 64'(o_data_bus), 64'hB0 + 64'(i));
        end
        step(0, 0, 0, 1, 0);
        chk("fill_b4", 64'(o_data_bus), 64'hB4);
        step(0, 0, 0, 1, 0);

        // Zero mask saturation
        for (int i = 0; i < 300; i++) step(1, 32'(i), 4'b0000, 1, 0);
        chk("drop_sat", 64'(o_drop_cnt), 64'd255);
        chk("drop_nothing_out", 64'(o_valid), 64'd0);

        // Mid-stream stall
        step(1, 32'hA1, 4'b0001, 1, 0);
        step(1, 32'hA2, 4'b0100, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk("stall_hold", 64'(o_data_bus), 64'hA1);
        end
        step(0, 0, 0, 1, 0);
        chk("stall_next", 64'(o_data_bus), 64'hA2);
        step(0, 0, 0, 1, 0);

        // Reset mid-operation
        for (int i = 0; i < 4; i++) step(1, 32'hC0 + i, 4'b1000, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("pre_rst_valid", 64'(o_valid), 64'd1);
        step(0, 0, 0, 1, 1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [NN-1:0] m;
            m = ($urandom_range(0, 7) == 0) ? '0 : NN'($urandom);
            step(1'($urandom_range(0, 2) != 0), $urandom, m,
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 499) == 0));
        end
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
        chk("drained", 64'(mfifo.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/distribute_chain_injector.md
# distribute_chain_injector

Head-of-chain source for the one-hot sequential distribution network. It accepts data words tagged with a destination node mask through a valid/ready handshake and buffers them in a small FIFO. It converts each mask into the MSB-first one-hot command consumed by the first `distribute_1x2_one_hot_seq` stage, and drives that stage's `i_valid`, `i_data_bus` and `i_cmd` from a registered output stage that stalls with the chain enable.

## Interface
Reset is synchronous, active-high (`rst`); there is one clock, `clk`.

Parameters:
- `DATA_WIDTH`, 32: payload width.
- `NUM_NODES`, 4: number of nodes on the chain; also the command width.
- `FIFO_DEPTH`, 4: buffer entries; must be a power of 2 and ≥2.
- `CNT_WIDTH`, `$clog2(FIFO_DEPTH)+1`: width of the occupancy count (localparam).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `i_valid`  in  1  upstream word valid.
- `o_ready`  out  1  injector can accept a word.
- `i_data_bus`  in  DATA_WIDTH  upstream payload.
- `i_dest_mask`  in  NUM_NODES  bit k set means deliver to node k (node 0 is first on the chain).
- `i_en`  in  1  chain enable; the same signal drives the `i_en` of the first chain stage.
- `o_valid`  out  1  to the first stage's `i_valid`.
- `o_data_bus`  out  DATA_WIDTH  to the first stage's `i_data_bus`.
- `o_cmd`  out  NUM_NODES  to the first stage's `i_cmd`.
- `o_count`  out  CNT_WIDTH  FIFO occupancy.
- `o_full`  out  1  occupancy == FIFO_DEPTH.
- `o_empty`  out  1  occupancy == 0.
- `o_drop_cnt`  out  8  saturating count of zero-mask words.

## Operation
- **Accept.** A word is accepted on a rising edge when `i_valid && o_ready`. `o_ready = !o_full`; there is no same-cycle bypass when full.
- **Mask conversion at write.** The FIFO stores `{cmd, data}` with `cmd[NUM_NODES-1-k] = i_dest_mask[k]`. The first node therefore consumes the MSB, matching the chain convention: 1 = output to node and pass on, 0 = pass only.
- **Zero mask.**
  - An accepted word with `i_dest_mask == 0` is dropped and not stored.
  - `o_drop_cnt` increments and saturates at 255.
  - `o_ready` is unaffected.
- **Output stage.** The registered output is `{o_valid, o_cmd, o_data_bus}`. On each edge:
  - `i_en=1` and the FIFO is non-empty: pop the head and load it with `o_valid=1`.
  - `i_en=1` and the FIFO is empty: load the dummy word, `o_valid=0`, `o_data_bus={DATA_WIDTH{1'b0}}`, `o_cmd=0`.
  - `i_en=0`: hold all three outputs and do not pop.
- **Simultaneous push and pop.** Push and pop in the same edge leave the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- **Order.** Words leave in strict FIFO order.

## Timing
- **Reset values.**
  - `o_valid=0`, `o_data_bus=0`, `o_cmd=0`.
  - `o_count=0`, `o_empty=1`, `o_full=0`, `o_ready=1`, `o_drop_cnt=0`.
  - Pointers are cleared.
  - Reset mid-operation discards all buffered entries and the output register contents in the same edge.
- **Latency.** A word accepted at edge N appears on `o_*` after edge N+1 at the earliest, provided `i_en=1` at N+1 and the FIFO was empty.
- **Throughput.** With `i_en` held at 1, one word is issued per cycle.
- **Stall.** While `i_en=0`, the outputs are stable for every cycle of the stall. The FIFO still accepts words until full.
- **Status outputs.** `o_count`, `o_full` and `o_empty` are registered and reflect the state after the last edge. `o_ready` is derived combinationally from `o_full`.
- **Full boundary.** At full, `i_valid=1` is ignored. A pop on that edge makes `o_ready=1` from the next cycle.

## Test plan
- **Single word.**
  - Stimulus: reset, then push `data=32'hAAAAAAAA`, `mask=4'b0001`, with `i_en=1`.
  - Required: one cycle later `o_valid=1`, `o_cmd=4'b1000`, `o_data_bus=32'hAAAAAAAA`; next cycle `o_valid=0`, `o_data_bus=0`.
- **Multicast.**
  - Stimulus: push `mask=4'b0101`.
  - Required: `o_cmd=4'b1010`. Push `mask=4'b1111` → `o_cmd=4'b1111`.
- **Fill and stall.**
  - Stimulus: hold `i_en=0` and push 5 words `32'hB0..B4` back to back.
  - Required: first 4 accepted; `o_full=1`, `o_ready=0`, `o_count=4`; 5th held off.
  - Then: raise `i_en`. Required: `B0..B3` issue in order on consecutive cycles, then `B4` is accepted and issued.
- **Zero mask.**
  - Stimulus: push `mask=0` 300 times.
  - Required: nothing stored; `o_valid` stays 0; `o_drop_cnt` saturates at 255.
- **Mid-stream stall.**
  - Stimulus: issue `32'hA1` with `i_en=1`, drop `i_en` for 3 cycles.
  - Required: `o_valid/o_cmd/o_data_bus` hold `A1` for all 3 cycles; next word appears one cycle after `i_en` returns.
- **Reset mid-operation.**
  - Stimulus: with 3 words buffered and `o_valid=1`, assert `rst` for one edge.
  - Required: all outputs at reset values on the next cycle; no buffered word is ever issued afterward.
